// File: rtl/fetch_decode_reg_if.sv
// IF/ID register bus: fetch-side inputs and decode-side outputs.
// master = fetch/decode environment, slave = the register.
interface fetch_decode_reg_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] instr_in;
  logic [ADDR_W-1:0] pc_in;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] instr_out;
  logic [DATA_W-1:0] imm_out;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_next_out;
  logic              valid_out;
  logic              wait_imm;
  logic [7:0]        bubble_cnt;

  modport master (
    output instr_in, pc_in, stall, flush,
    input  instr_out, imm_out, pc_out, pc_next_out,
    input  valid_out, wait_imm, bubble_cnt
  );

  modport slave (
    input  instr_in, pc_in, stall, flush,
    output instr_out, imm_out, pc_out, pc_next_out,
    output valid_out, wait_imm, bubble_cnt
  );
endinterface

// File: rtl/fetch_decode_reg.sv
// IF/ID register: assembles 1/2-byte instructions into decode packets.
// Optional bubble counter enabled by macro IFID_BUBBLE_COUNT_EN.
module fetch_decode_reg #(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 8,
  parameter logic [3:0]  TWO_BYTE_OP = 4'd12
) (
  input logic clk,
  input logic reset,
  fetch_decode_reg_if.slave bus
);

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] imm_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next_q;
  logic              valid_q;
  logic [DATA_W-1:0] pend_op_q;
  logic [ADDR_W-1:0] pend_pc_q;

  logic two_byte;
  logic [ADDR_W-1:0] pc_inc;

  assign two_byte = (bus.instr_in[DATA_W-1 -: 4] == TWO_BYTE_OP);
  assign pc_inc   = bus.pc_in + ADDR_W'(1);

  // packet assembly FSM: flush beats stall beats capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_OP;
      instr_q   <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      pend_op_q <= '0;
      pend_pc_q <= '0;
    end else if (bus.flush) begin
      state_q   <= S_OP;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      imm_q     <= '0;
      pend_op_q <= '0;
      pend_pc_q <= '0;
    end else if (!bus.stall) begin
      unique case (state_q)
        S_OP: begin
          if (two_byte) begin
            pend_op_q <= bus.instr_in;
            pend_pc_q <= bus.pc_in;
            valid_q   <= 1'b0;
            state_q   <= S_IMM;
          end else begin
            instr_q   <= bus.instr_in;
            imm_q     <= '0;
            pc_q      <= bus.pc_in;
            pc_next_q <= pc_inc;
            valid_q   <= 1'b1;
          end
        end
        S_IMM: begin
          instr_q   <= pend_op_q;
          imm_q     <= bus.instr_in;
          pc_q      <= pend_pc_q;
          pc_next_q <= pc_inc;
          valid_q   <= 1'b1;
          state_q   <= S_OP;
        end
        default: state_q <= S_OP;
      endcase
    end
  end

  assign bus.instr_out   = instr_q;
  assign bus.imm_out     = imm_q;
  assign bus.pc_out      = pc_q;
  assign bus.pc_next_out = pc_next_q;
  assign bus.valid_out   = valid_q;
  assign bus.wait_imm    = (state_q == S_IMM);

`ifdef IFID_BUBBLE_COUNT_EN
  logic [7:0] bub_q;
  logic [7:0] bub_d;
  logic       bub_inc;

  assign bub_inc = bus.flush ||
                   (!bus.stall && state_q == S_OP && two_byte);
  assign bub_d   = (bub_inc && bub_q != 8'hFF) ? bub_q + 8'd1 : bub_q;

  // saturating count of edges that load a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bub_q <= 8'h00;
    end else begin
      bub_q <= bub_d;
    end
  end

  assign bus.bubble_cnt = bub_q;
`else
  assign bus.bubble_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Scoreboard bench for fetch_decode_reg (random + directed).
// Expected bubble count follows macro IFID_BUBBLE_COUNT_EN.
module tb_fetch_decode_reg;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  fetch_decode_reg_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  fetch_decode_reg #(
    .DATA_W(8), .ADDR_W(8), .TWO_BYTE_OP(4'd12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc;
    logic [7:0] pcn;
    logic       valid;
    logic       wt;
    logic [7:0] bc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

`ifdef IFID_BUBBLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // reference model: a visible packet plus an optional half-built one
  exp_t       m;
  bit         have_half;
  logic [7:0] half_op;
  logic [7:0] half_pc;
  int         bubbles;

  function automatic void add_bubble();
    if (bubbles < 255) bubbles++;
  endfunction

  function automatic void model_step(
    input logic r, input logic [7:0] i, input logic [7:0] p,
    input logic s, input logic f
  );
    if (!r) begin
      m = '0;
      have_half = 0;
      half_op = 0;
      half_pc = 0;
      bubbles = 0;
    end else if (f) begin
      m.valid = 0;
      m.instr = 0;
      m.imm = 0;
      have_half = 0;
      add_bubble();
    end else if (!s) begin
      if (have_half) begin
        m.instr = half_op;
        m.imm = i;
        m.pc = half_pc;
        m.pcn = 8'((int'(p) + 1) % 256);
        m.valid = 1;
        have_half = 0;
      end else if (i / 16 == 12) begin
        half_op = i;
        half_pc = p;
        have_half = 1;
        m.valid = 0;
        add_bubble();
      end else begin
        m.instr = i;
        m.imm = 0;
        m.pc = p;
        m.pcn = 8'((int'(p) + 1) % 256);
        m.valid = 1;
      end
    end
    m.wt = have_half;
    m.bc = CNT_EN ? 8'(bubbles) : 8'h00;
  endfunction

  function automatic void chk(input string nm, input int act, input int exv);
    checks++;
    if (act != exv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exv, $time);
    end
  endfunction

  // drive one cycle at the falling edge and queue its expected result
  task automatic cyc(
    input logic r, input logic [7:0] i, input logic [7:0] p,
    input logic s, input logic f
  );
    @(negedge clk);
    reset = r;
    bus.instr_in = i;
    bus.pc_in = p;
    bus.stall = s;
    bus.flush = f;
    model_step(r, i, p, s, f);
    exp_q.push_back(m);
    if (!r) begin
      #1;
      chk("async_rst_instr", int'(bus.instr_out), 0);
      chk("async_rst_valid", int'(bus.valid_out), 0);
      chk("async_rst_wait", int'(bus.wait_imm), 0);
      chk("async_rst_pcn", int'(bus.pc_next_out), 0);
      chk("async_rst_bc", int'(bus.bubble_cnt), 0);
    end
  endtask

  // monitor: compare DUT outputs after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("instr_out", int'(bus.instr_out), int'(e.instr));
        chk("imm_out", int'(bus.imm_out), int'(e.imm));
        chk("pc_out", int'(bus.pc_out), int'(e.pc));
        chk("pc_next_out", int'(bus.pc_next_out), int'(e.pcn));
        chk("valid_out", int'(bus.valid_out), int'(e.valid));
        chk("wait_imm", int'(bus.wait_imm), int'(e.wt));
        chk("bubble_cnt", int'(bus.bubble_cnt), int'(e.bc));
      end
    end
  end

  initial begin
    logic [7:0] pc;
    logic [7:0] ib;
    bus.instr_in = 0;
    bus.pc_in = 0;
    bus.stall = 0;
    bus.flush = 0;
    model_step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(0, 8'h00, 8'h00, 0, 0);
    cyc(0, 8'h00, 8'h00, 0, 0);
    // one-byte after reset
    cyc(1, 8'h25, 8'h10, 0, 0);
    // two-byte
    cyc(1, 8'hC3, 8'h20, 0, 0);
    cyc(1, 8'h7F, 8'h21, 0, 0);
    // stall during S_IMM
    cyc(1, 8'hC3, 8'h30, 0, 0);
    repeat (3) cyc(1, 8'hAA, 8'h31, 1, 0);
    cyc(1, 8'h05, 8'h31, 0, 0);
    // flush + stall together while pending
    cyc(1, 8'hC3, 8'h40, 0, 0);
    cyc(1, 8'h99, 8'h41, 1, 1);
    cyc(1, 8'h12, 8'h42, 0, 0);
    // pc wrap and immediate that looks like an opcode
    cyc(1, 8'hC0, 8'hFE, 0, 0);
    cyc(1, 8'hC1, 8'hFF, 0, 0);
    cyc(1, 8'h33, 8'h00, 0, 0);
    // reset mid-S_IMM
    cyc(1, 8'hC7, 8'h50, 0, 0);
    cyc(0, 8'h44, 8'h51, 0, 0);
    cyc(1, 8'h44, 8'h51, 0, 0);
    // randomized traffic
    pc = 8'h60;
    for (int n = 0; n < 400; n++) begin
      ib = 8'($urandom);
      if ($urandom_range(0, 2) == 0) ib[7:4] = 4'hC;
      if ($urandom_range(0, 9) == 0) pc = 8'($urandom);
      cyc(($urandom_range(0, 99) != 0), ib, pc,
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      pc = pc + 8'd1;
    end
    cyc(0, 8'h00, 8'h00, 0, 0);
    // saturation of the bubble counter
    repeat (300) cyc(1, 8'h11, 8'h22, 0, 1);
    cyc(1, 8'h11, 8'h22, 0, 0);
    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 5; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_reg.md
# fetch_decode_reg

IF/ID pipeline register sitting directly downstream of the fetch-stage control unit. Captures the byte fetched from instruction memory each cycle, assembles two-byte instructions (opcode byte + immediate/EA byte) into one decode packet, and presents it to the decode stage with a valid flag. Honours the fetch controller's stall and flush outputs and inserts bubbles where needed.

## Interface
Parameters:
- DATA_W, 8, instruction/immediate byte width
- ADDR_W, 8, PC width
- TWO_BYTE_OP, 4'd12, opcode value (instr[7:4]) marking a two-byte instruction

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low
- instr_in  in  DATA_W  byte read from instruction memory this cycle
- pc_in  in  ADDR_W  address of instr_in
- stall  in  1  hold all state (from fetch CU `stall` or decode hazard)
- flush  in  1  discard contents (fetch CU `flush_next`, taken branch, interrupt)
- instr_out  out  DATA_W  opcode byte of the current decode packet
- imm_out  out  DATA_W  immediate/EA byte; 0 for one-byte instructions
- pc_out  out  ADDR_W  address of the opcode byte
- pc_next_out  out  ADDR_W  address of the following instruction (return address for CALL)
- valid_out  out  1  packet valid; 0 = bubble
- wait_imm  out  1  high while in S_IMM (opcode held, immediate byte expected)
- bubble_cnt  out  8  bubbles inserted (see Configuration)

## Operation
- Reset (reset=0, async): state=S_OP; instr_out=0, imm_out=0, pc_out=0, pc_next_out=0, valid_out=0, wait_imm=0, pending regs=0, bubble_cnt=0.
- Priority per edge: flush > stall > normal capture.
- flush=1: state<=S_OP, valid_out<=0, instr_out<=0, imm_out<=0; pending opcode discarded; pc_out/pc_next_out hold. Applies in either state, regardless of stall.
- stall=1, flush=0: every register holds, including state and bubble_cnt.
- States:
  - S_OP: capture instr_in. If instr_in[7:4]==TWO_BYTE_OP: pending_op<=instr_in, pending_pc<=pc_in, valid_out<=0, -> S_IMM. Else: instr_out<=instr_in, imm_out<=0, pc_out<=pc_in, pc_next_out<=pc_in+1, valid_out<=1, stay S_OP.
  - S_IMM: instr_out<=pending_op, imm_out<=instr_in, pc_out<=pending_pc, pc_next_out<=pc_in+1, valid_out<=1, -> S_OP. Byte in S_IMM is never decoded as an opcode even if its top nibble equals TWO_BYTE_OP.
- pc+1 arithmetic modulo 2^ADDR_W (8'hFF+1 = 8'h00). pc_in of the immediate byte need not equal pending_pc+1; pc_next_out always uses the immediate byte's own pc_in.
- wait_imm = (state==S_IMM), registered-state decode, no combinational path from inputs.

## Timing
- Latency: one-byte instruction visible on outputs 1 cycle after capture edge; two-byte packet valid 1 cycle after the immediate byte edge (2 edges after opcode byte), with one bubble cycle in between.
- All outputs registered; no input-to-output combinational path.
- Stall during S_IMM: stays S_IMM, immediate captured on first non-stalled edge.
- Flush and stall same cycle: flush wins.
- Reset mid-S_IMM: pending opcode lost, returns to S_OP asynchronously.

## Configuration
- IFID_BUBBLE_COUNT_EN defined: bubble_cnt is an 8-bit saturating counter (stops at 255) incremented on every non-stalled edge where valid_out is loaded with 0 (flush or S_OP->S_IMM). Cleared only by reset.
- Not defined: bubble_cnt tied to 8'h00, no counter register synthesised.

## Test plan
- Reset: drive reset=0 mid-run -> all outputs 0, wait_imm=0 immediately; release, instr_in=8'h25 pc_in=8'h10 -> next cycle instr_out=8'h25, imm_out=0, pc_out=8'h10, pc_next_out=8'h11, valid_out=1.
- Two-byte: 8'hC3@8'h20 then 8'h7F@8'h21 -> cycle1 valid_out=0, wait_imm=1; cycle2 instr_out=8'hC3, imm_out=8'h7F, pc_out=8'h20, pc_next_out=8'h22, valid_out=1; bubble_cnt=1 (with macro).
- Stall: 8'hC3@8'h30, stall=1 for 3 cycles with instr_in=8'hAA, then 8'h05@8'h31 -> outputs frozen, wait_imm=1 throughout; then imm_out=8'h05, valid_out=1.
- Flush: 8'hC3 captured, then flush=1 together with stall=1 -> valid_out=0, wait_imm=0, instr_out=0; next 8'h12 captured as one-byte instruction.
- Wrap/immediate masquerade: 8'hC0@8'hFE then 8'hC1@8'hFF -> imm_out=8'hC1, pc_next_out=8'h00, state returns to S_OP.
- Saturation (macro on): 300 consecutive flush edges -> bubble_cnt=255; macro off -> bubble_cnt=0.
